line_window_5x5: RTL
====================

Name: line_window_5x5

Overview:
- Downstream consumer of the six-line rotating buffer bank.
- On each start pulse it sweeps the read address across one line and feeds read_enable/address_out to the buffer bank.
- It captures the five row outputs (oldest row on data_in_1, newest on data_in_5) into a 5x5 sliding pixel window.
- It presents one window per column, with x/y coordinates, to the stereo matching cost stage.

Parameters:
- WIDTH, 640, pixels per line; legal range 5..2^ADDR_BITS.
- ADDR_BITS, 10, width of the buffer read address.
- DATA_BITS, 8, pixel width.
- Y_BITS, 9, width of the line (y) counter.

Ports:
- clock  in  1  single clock; same clock as the buffer-bank read port.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: five valid rows are available; accepted only in IDLE.
- frame_start  in  1  clears the y counter; honoured only in IDLE.
- data_in_1..data_in_5  in  DATA_BITS each  buffer-bank row outputs; data_in_1 is the top (oldest) row.
- read_enable  out  1  buffer read enable.
- address_out  out  ADDR_BITS  buffer read address.
- window_out  out  25*DATA_BITS  pixel (r,c) at bits [(r*5+c)*DATA_BITS +: DATA_BITS]; r=0 is the top row, c=0 is the leftmost/oldest column.
- window_valid  out  1  window_out, window_x and window_y are valid this cycle.
- window_x  out  ADDR_BITS  centre-column address (newest column - 2).
- window_y  out  Y_BITS  current line index.
- line_done  out  1  one-cycle pulse coinciding with the last window of the line.
- busy  out  1  high in READ and DRAIN.
- overrun  out  1  sticky: start arrived while busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, window registers 0, column and y counters 0. Reset mid-line aborts the sweep immediately: no further window_valid or line_done, and the next start begins at address 0.
- Buffer read latency is fixed at 1 cycle: the address presented in cycle t produces data on data_in_* in cycle t+1.
- FSM states and transitions:
  - IDLE: read_enable=0. start=1 -> READ, address_out=0.
  - READ: read_enable=1. address_out increments by 1 each cycle. In the cycle address_out=WIDTH-1 -> DRAIN next cycle.
  - DRAIN: read_enable=0. Lasts 2 cycles, then -> IDLE.
- Read pipeline: a 1-cycle delayed copy of read_enable (data-valid) marks cycles where data_in_* is valid. On each such edge, every row shifts left by one column; column c=4 takes data_in_(r+1).
- Column counter: counts shifted columns, saturating at 5, cleared on entry to READ. Window contents persist across lines but are ignored until 5 new columns have been shifted.
- window_valid is registered: high the cycle after a shift that leaves the column count >= 5.
- window_x = newest shifted address - 2; window_y = y counter.
- Timing, with start sampled at edge k:
  - address 0 in cycle k+1;
  - address WIDTH-1 in cycle k+WIDTH;
  - first window_valid in cycle k+7 (window_x=2);
  - last window_valid and line_done in cycle k+WIDTH+2 (window_x=WIDTH-3);
  - WIDTH-4 windows per line, contiguous with no gaps;
  - busy high in cycles k+1..k+WIDTH+2.
- y counter: increments on line_done (wraps at 2^Y_BITS). frame_start in IDLE sets it to 0; if frame_start and start coincide, y=0 is applied first and the line is processed as y=0.
- start while busy: ignored, overrun set to 1 and held until reset.
- start and frame_start in the same cycle as line_done are ignored (state is not yet IDLE). start in that cycle also sets overrun.
- No backpressure: the consumer must accept a window every cycle window_valid is high.
- Address arithmetic: ADDR_BITS wide; address_out never exceeds WIDTH-1.

Test Plan:
- Single line, WIDTH=8, row r returns pixel value 16*r+address -> 4 windows. The first window (cycle k+7, x=2) has window_out(r,c)=16*r+c. The last window (x=5) has (r,c)=16*r+3+c. line_done coincides with the x=5 window; busy high for exactly 10 cycles.
- Minimum WIDTH=5 -> exactly one window_valid cycle (x=2) with line_done in the same cycle; read_enable high for 5 cycles.
- Three back-to-back lines, each start issued in the first IDLE cycle -> window_y=0,1,2; no window_valid from a new line before its 5th column; overrun stays 0.
- start pulsed mid-READ at address 3 -> overrun=1 permanently; the current line completes unchanged; no extra sweep starts.
- reset asserted in the cycle address_out=6 (WIDTH=16) -> the next cycle has read_enable=0, window_valid=0, busy=0, window_y=0. A following start yields first window x=2 at k+7.
- frame_start pulsed in IDLE after two lines (y=2) -> the next line reports window_y=0. frame_start pulsed during READ -> no effect on y.

Source files
------------

// File: rtl/line_window_5x5.sv
// rtl/line_window_5x5.sv - 5x5 sliding pixel window fed from the six-line buffer bank
//
// Sweeps the buffer read address across one line per start pulse and assembles
// a 5x5 window from the five row outputs, one window per column.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   start               one-cycle pulse, five rows available (accepted in IDLE)
//   frame_start         clears the line counter (honoured in IDLE)
//   data_in_1..5        buffer row outputs, data_in_1 = top/oldest row
//   read_enable         buffer read enable
//   address_out         buffer read address
//   window_out          pixel (r,c) at [(r*5+c)*DATA_BITS +: DATA_BITS]
//   window_valid        window_out/window_x/window_y valid this cycle
//   window_x, window_y  centre column address and line index
//   line_done           pulse with the last window of the line
//   busy                sweep or drain in progress
//   overrun             sticky, start seen while busy

module line_window_5x5 #(
  parameter int WIDTH     = 640,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8,
  parameter int Y_BITS    = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    frame_start,
  input  logic [DATA_BITS-1:0]    data_in_1,
  input  logic [DATA_BITS-1:0]    data_in_2,
  input  logic [DATA_BITS-1:0]    data_in_3,
  input  logic [DATA_BITS-1:0]    data_in_4,
  input  logic [DATA_BITS-1:0]    data_in_5,
  output logic                    read_enable,
  output logic [ADDR_BITS-1:0]    address_out,
  output logic [25*DATA_BITS-1:0] window_out,
  output logic                    window_valid,
  output logic [ADDR_BITS-1:0]    window_x,
  output logic [Y_BITS-1:0]       window_y,
  output logic                    line_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                 state;
  logic                   drain_last;
  logic                   data_valid;
  logic [ADDR_BITS-1:0]   data_addr;
  logic [2:0]             col_count;
  logic [DATA_BITS-1:0]   win    [5][5];
  logic [DATA_BITS-1:0]   row_in [5];

  assign row_in[0] = data_in_1;
  assign row_in[1] = data_in_2;
  assign row_in[2] = data_in_3;
  assign row_in[3] = data_in_4;
  assign row_in[4] = data_in_5;

  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      assign window_out[(r*5+c)*DATA_BITS +: DATA_BITS] = win[r][c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      drain_last   <= 1'b0;
      read_enable  <= 1'b0;
      address_out  <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      data_valid   <= 1'b0;
      data_addr    <= '0;
      col_count    <= '0;
      window_valid <= 1'b0;
      window_x     <= '0;
      window_y     <= '0;
      line_done    <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      // Read latency is one cycle: data_in_* this cycle belongs to last cycle's address.
      data_valid   <= read_enable;
      data_addr    <= address_out;
      window_valid <= 1'b0;
      line_done    <= 1'b0;

      if (data_valid) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][4] <= row_in[r];
        end
        if (col_count != 3'd5) begin
          col_count <= col_count + 3'd1;
        end
        // Pre-shift count of 4 or more means this shift completes a full window.
        if (col_count >= 3'd4) begin
          window_valid <= 1'b1;
          window_x     <= data_addr - ADDR_BITS'(2);
          line_done    <= (data_addr == LAST_ADDR);
        end
      end

      if (line_done) begin
        window_y <= window_y + Y_BITS'(1);
      end

      if (start && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          // frame_start is written before the start branch so a coincident start
          // sweeps this line as y = 0.
          if (frame_start) begin
            window_y <= '0;
          end
          if (start) begin
            state       <= READ;
            read_enable <= 1'b1;
            address_out <= '0;
            busy        <= 1'b1;
            col_count   <= '0;
          end
        end
        READ: begin
          if (address_out == LAST_ADDR) begin
            state       <= DRAIN;
            read_enable <= 1'b0;
            drain_last  <= 1'b0;
          end else begin
            address_out <= address_out + ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          // Two cycles let the last column pass the read and window registers.
          if (drain_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_last <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
